// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO: a ceiling-log2
// helper, default geometry and the parameter legality test used at elaboration.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // Smallest n with 2**n >= value; used to size address and pointer fields.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Geometry is legal when depth is a power of two of at least four and the
  // thresholds are ordered so almost_empty and almost_full never overlap.
  function automatic bit fifo_params_ok(input int data_w, input int depth,
                                        input int af_level, input int ae_level);
    bit pow2;
    pow2 = (depth >= 4) && ((depth & (depth - 1)) == 0);
    return (data_w >= 1) && pow2 && (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port and one registered
// read port. Only the read register is reset; array contents are not.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming word; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Capture the addressed word on a read and hold it otherwise. A same-edge
  // write to the same slot lands after this sample, so the old word is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags,
// synchronous flush and one-cycle registered read data with a valid strobe.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CNT_W   = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              clr_err,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = CNT_W - 1;
  localparam logic [CNT_W-1:0] AF_CNT = AF_LEVEL[CNT_W-1:0];
  localparam logic [CNT_W-1:0] AE_CNT = AE_LEVEL[CNT_W-1:0];

  if (!fifo_params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic rd_ok;
  logic wr_ok;
  logic do_rd;
  logic do_wr;
  logic ovf_set;
  logic udf_set;

  // Status comes straight from the registered pointers, so it never depends
  // on the current cycle's requests and carries no extra lag.
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count        = wr_ptr - rd_ptr;
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
  end

  // Accept/reject decisions. A write on full is still taken when a read frees
  // a slot in the same cycle. Flush drops both requests, and dropped requests
  // are not counted as errors.
  always_comb begin
    rd_ok   = rd_en & ~empty;
    wr_ok   = wr_en & (~full | rd_ok);
    do_rd   = rd_ok & ~flush;
    do_wr   = wr_ok & ~flush;
    ovf_set = wr_en & ~wr_ok & ~flush;
    udf_set = rd_en & empty & ~flush;
  end

  // Pointer advance; the extra MSB wraps naturally and keeps full/empty apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Valid strobe marks the cycle in which data_out carries a freshly read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_valid <= 1'b0;
    else     rd_valid <= do_rd;
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= udf_set | (underflow & ~clr_err);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (do_wr),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_en   (do_rd),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (data_out)
  );

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO with configurable data width and power-of-two depth. It adds fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush and registered read data with a valid strobe. It is the standard on-chip buffer between producer and consumer logic sharing one clock, and it replaces ad-hoc fixed 8x32 buffers.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, entry count; power of two, ≥4
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- CNT_W, clog2(DEPTH)+1, derived localparam; not overridable

- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents
- clr_err  in  1  synchronous clear of sticky error flags
- wr_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request
- data_out  out  DATA_W  read data, registered
- rd_valid  out  1  data_out holds a newly read word this cycle
- full, empty  out  1 each  status flags
- almost_full, almost_empty  out  1 each  threshold flags
- count  out  CNT_W  current occupancy, 0..DEPTH
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Pointers wr_ptr and rd_ptr are each CNT_W bits: the low bits address memory, and the MSB is a wrap bit.
  - empty when the pointers are equal.
  - full when the MSBs differ and the low bits are equal.
  - count is the difference wr_ptr − rd_ptr, taken modulo 2^CNT_W.
- rd_ok = rd_en & !empty.
- wr_ok = wr_en & (!full | rd_ok). A write on full is accepted when a read is accepted in the same cycle.
- Accepted write: mem[wr_ptr low bits] ← data_in, then wr_ptr+1.
- Accepted read: data_out ← mem[rd_ptr low bits], rd_valid=1 next cycle, then rd_ptr+1.
- Simultaneous accepted read and write: count is unchanged. On empty, only the write proceeds; a read never bypasses the write.
- Rejected write (wr_en & !wr_ok) sets overflow. Rejected read (rd_en & empty) sets underflow. Both flags are sticky.
- clr_err clears both flags. If a new error occurs in the same cycle, the set wins.
- flush zeroes both pointers and has priority over wr_en/rd_en in that cycle: no write, no read, rd_valid=0 next cycle. The error flags and data_out are unaffected.
- Status flags are derived combinationally from the registered pointers, so they carry no extra lag.
- Memory content is not reset.

## Timing
- Reset values: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0, data_out=0.
- Asserting rst mid-operation takes effect immediately, without waiting for a clock edge. Stored data is logically lost.
- Read latency is one cycle: rd_en sampled at edge N yields data_out and rd_valid=1 after edge N+1's register update, visible in cycle N+1.
- data_out holds its value while rd_valid=0.
- Write-to-empty-deassert takes one cycle: empty falls in the cycle after the accepting edge.
- Pointers wrap from 2^CNT_W−1 to 0 naturally. The count arithmetic must remain correct across the wrap.
- No combinational path from wr_en/rd_en to any output.

## Structure
- Package fifo_pkg holds:
  - a clog2 function;
  - default width/depth constants;
  - the elaboration-time checks (DEPTH power of two, AE_LEVEL < AF_LEVEL ≤ DEPTH), which must fail elaboration if violated.
- Sub-module fifo_mem: simple dual-port RAM with one synchronous write port and one registered read port, parametrised by DATA_W and DEPTH.
- Top level holds the pointers, flag logic and error registers.

## Test plan
All scenarios use DATA_W=8, DEPTH=8, AF=6, AE=2.
- Reset, then write 0x11..0x88 → count steps 1..8; almost_full at count 6; full=1 at 8; overflow stays 0.
- Full, then a lone write of 0x99 → rejected, overflow=1, count=8. Then assert clr_err → overflow=0.
- Full, then simultaneous write 0xAA + read → data_out=0x11 next cycle, count stays 8, 0xAA read last after 0x22..0x88.
- Drain to empty, then read → underflow=1, rd_valid=0, data_out holds the last value.
- 20 write/read pairs crossing the pointer wrap twice → data order preserved and count correct throughout.
- Flush at count 5 → count=0, empty=1 next cycle. Then assert rst mid-burst → all outputs at reset values with no clock edge.
